// File: rtl/mdu_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// mdu_ctrl
// Multi-cycle multiply/divide sequencer for the EX stage. It accepts one
// HI/LO-class operation per handshake. Multiply-class ops go through a 2-cycle
// registered multiplier, with optional accumulate into or subtract from the
// forwarded {HI,LO}. Divides run a 32-iteration restoring divider. The block
// holds the front of the pipeline with stall_o until the result is ready.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-low reset
//   op_valid_i     EX holds a mult/div-class instruction (held while stalled)
//   op_i           operation code (MULT/MULTU/DIV/DIVU/MADD(U)/MSUB(U)/MUL)
//   src_a_i        rs operand (dividend / multiplicand)
//   src_b_i        rt operand (divisor / multiplier)
//   hilo_i         forwarded {HI,LO}, used by the MADD/MSUB family
//   stall_ext_i    EX held by another stall source
//   flush_i        exception/eret flush of EX
//   stall_o        hold IF..EX
//   result_o       {HI,LO} result (MUL writes result_o[31:0] to a GPR)
//   result_valid_o result_o valid this cycle
//   hilo_wen_o     write result_o into HI/LO
//   busy_o         sequencer not idle
// ---------------------------------------------------------------------------
module mdu_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  input  logic [63:0] hilo_i,
  input  logic        stall_ext_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic [63:0] result_o,
  output logic        result_valid_o,
  output logic        hilo_wen_o,
  output logic        busy_o
);

  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b0001;
  localparam logic [3:0] OP_DIV   = 4'b0010;
  localparam logic [3:0] OP_DIVU  = 4'b0011;
  localparam logic [3:0] OP_MADD  = 4'b0100;
  localparam logic [3:0] OP_MADDU = 4'b0101;
  localparam logic [3:0] OP_MSUB  = 4'b0110;
  localparam logic [3:0] OP_MSUBU = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Divide-class opcodes; everything else, including unknown codes, multiplies.
  function automatic logic op_is_div(input logic [3:0] op);
    logic d;
    case (op)
      OP_DIV, OP_DIVU: d = 1'b1;
      default:         d = 1'b0;
    endcase
    return d;
  endfunction

  // Opcodes that treat their operands as two's-complement values.
  function automatic logic op_is_signed(input logic [3:0] op);
    logic s;
    case (op)
      OP_MULT, OP_DIV, OP_MADD, OP_MSUB, OP_MUL: s = 1'b1;
      default:                                   s = 1'b0;
    endcase
    return s;
  endfunction

  // Two's-complement negate when requested (also yields the magnitude).
  function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
    logic [31:0] r;
    if (neg) begin
      r = 32'd0 - v;
    end else begin
      r = v;
    end
    return r;
  endfunction

  // Sequencer and latched operation
  state_t      state_r;
  state_t      state_nxt_s;
  logic [3:0]  op_r;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [63:0] hilo_r;

  // Multiplier path
  logic        mul_cnt_r;
  logic [63:0] prod_r;
  logic        mul_sgn_s;
  logic [63:0] a_ext_s;
  logic [63:0] b_ext_s;
  logic [63:0] prod_s;
  logic [63:0] mul_res_s;

  // Divider path
  logic [4:0]  div_cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvsr_r;
  logic        neg_q_r;
  logic        neg_r_r;
  logic        div_sgn_s;
  logic [32:0] rem_sh_s;
  logic [32:0] trial_s;
  logic [31:0] rem_nxt_s;
  logic [31:0] quo_nxt_s;
  logic [63:0] div_res_s;

  // Result registers
  logic [63:0] result_r;
  logic        result_valid_r;
  logic        hilo_wen_r;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; a flush always returns to IDLE and DONE waits out external stalls
  always_comb begin
    state_nxt_s = state_r;
    if (flush_i) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (op_valid_i) begin
            state_nxt_s = op_is_div(op_i) ? ST_DIV : ST_MUL;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_MUL: begin
          if (mul_cnt_r) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_MUL;
          end
        end
        ST_DIV: begin
          if (div_cnt_r == 5'd31) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_DIV;
          end
        end
        ST_DONE: begin
          if (stall_ext_i) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Outputs; the flush cycle suppresses the result strobe and HI/LO write
  always_comb begin
    stall_o        = 1'b0;
    if (rst && !flush_i) begin
      stall_o = ((state_r == ST_IDLE) && op_valid_i) ||
                (state_r == ST_MUL) || (state_r == ST_DIV);
    end else begin
      stall_o = 1'b0;
    end
    result_o       = result_r;
    result_valid_o = result_valid_r & ~flush_i;
    hilo_wen_o     = hilo_wen_r & ~flush_i;
    busy_o         = (state_r != ST_IDLE);
  end

  // Multiplier: sign- or zero-extend to 64 bits so the low 64 product bits are
  // right for both signednesses; then accumulate from the latched HI/LO.
  always_comb begin
    mul_sgn_s = op_is_signed(op_r);
    a_ext_s   = {{32{mul_sgn_s & a_r[31]}}, a_r};
    b_ext_s   = {{32{mul_sgn_s & b_r[31]}}, b_r};
    prod_s    = a_ext_s * b_ext_s;
    case (op_r)
      OP_MADD, OP_MADDU: mul_res_s = hilo_r + prod_r;
      OP_MSUB, OP_MSUBU: mul_res_s = hilo_r - prod_r;
      default:           mul_res_s = prod_r;
    endcase
  end

  // Divider: one restoring shift-subtract step per cycle; the final step also
  // applies the signs and the divide-by-zero result.
  always_comb begin
    div_sgn_s = (op_i == OP_DIV);
    rem_sh_s  = {rem_r, quo_r[31]};
    trial_s   = rem_sh_s - {1'b0, dvsr_r};
    if (!trial_s[32]) begin
      rem_nxt_s = trial_s[31:0];
      quo_nxt_s = {quo_r[30:0], 1'b1};
    end else begin
      rem_nxt_s = rem_sh_s[31:0];
      quo_nxt_s = {quo_r[30:0], 1'b0};
    end
    if (b_r == 32'd0) begin
      div_res_s = {a_r, 32'hFFFF_FFFF};
    end else begin
      div_res_s = {neg_if(rem_nxt_s, neg_r_r), neg_if(quo_nxt_s, neg_q_r)};
    end
  end

  // Datapath registers: operand capture, multiply/divide progress, result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_r           <= 4'd0;
      a_r            <= 32'd0;
      b_r            <= 32'd0;
      hilo_r         <= 64'd0;
      mul_cnt_r      <= 1'b0;
      prod_r         <= 64'd0;
      div_cnt_r      <= 5'd0;
      rem_r          <= 32'd0;
      quo_r          <= 32'd0;
      dvsr_r         <= 32'd0;
      neg_q_r        <= 1'b0;
      neg_r_r        <= 1'b0;
      result_r       <= 64'd0;
      result_valid_r <= 1'b0;
      hilo_wen_r     <= 1'b0;
    end else if (flush_i) begin
      // Abandon any partial work; result_r keeps the last completed value.
      mul_cnt_r      <= 1'b0;
      div_cnt_r      <= 5'd0;
      result_valid_r <= 1'b0;
      hilo_wen_r     <= 1'b0;
    end else begin
      result_valid_r <= (state_nxt_s == ST_DONE);
      hilo_wen_r     <= (state_nxt_s == ST_DONE) && (op_r != OP_MUL);
      case (state_r)
        ST_IDLE: begin
          if (op_valid_i) begin
            op_r      <= op_i;
            a_r       <= src_a_i;
            b_r       <= src_b_i;
            hilo_r    <= hilo_i;
            mul_cnt_r <= 1'b0;
            div_cnt_r <= 5'd0;
            // Divider setup: magnitudes and sign fix-ups captured at accept.
            rem_r     <= 32'd0;
            quo_r     <= neg_if(src_a_i, div_sgn_s & src_a_i[31]);
            dvsr_r    <= neg_if(src_b_i, div_sgn_s & src_b_i[31]);
            neg_q_r   <= div_sgn_s & (src_a_i[31] ^ src_b_i[31]);
            neg_r_r   <= div_sgn_s & src_a_i[31];
          end
        end
        ST_MUL: begin
          if (!mul_cnt_r) begin
            prod_r    <= prod_s;
            mul_cnt_r <= 1'b1;
          end else begin
            result_r  <= mul_res_s;
            mul_cnt_r <= 1'b0;
          end
        end
        ST_DIV: begin
          rem_r     <= rem_nxt_s;
          quo_r     <= quo_nxt_s;
          div_cnt_r <= div_cnt_r + 5'd1;
          if (div_cnt_r == 5'd31) begin
            result_r <= div_res_s;
          end
        end
        default: begin
          // DONE holds the result until the pipeline moves on.
        end
      endcase
    end
  end

endmodule
